// File: rtl/fwd_pkg.sv
// Shared constants and types for the forwarding / hazard unit and its
// multi-cycle scoreboard.
package fwd_pkg;

  localparam int FWD_RF  = 0;
  localparam int STG_MEM = 0;
  localparam int STG_WB  = 1;

  localparam int RA_W_DEF = 5;
  typedef logic [RA_W_DEF-1:0] reg_addr_t;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // Select encoding: 0 = regfile, k+1 = stage k, so one extra code is needed.
  function automatic int sel_w(input int num_fwd_stages);
    return (num_fwd_stages + 1 <= 1) ? 1 : $clog2(num_fwd_stages + 1);
  endfunction

endpackage

// File: rtl/md_scoreboard.sv
// Tracks one outstanding multi-cycle (mul/div) op: busy, countdown, pending
// destination, completion pulse, flush. FSM state is exposed on state.
module md_scoreboard
  import fwd_pkg::*;
#(
  parameter int RA_W   = 5,
  parameter int MD_LAT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            stall_other,
  input  logic            flush,
  input  logic [RA_W-1:0] rd,
  output md_state_e       state,
  output logic [RA_W-1:0] pend_rd,
  output logic            wb_valid,
  output logic [RA_W-1:0] wb_rd,
  output logic            accept,
  output logic            struct_stall
);

  localparam int CW = $clog2(MD_LAT + 1);

  md_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RA_W-1:0] pend_q, pend_d;
  logic            busy, cnt_zero, can_issue;

  assign busy      = (state_q == MD_BUSY);
  assign cnt_zero  = (cnt_q == '0);
  assign can_issue = !busy || cnt_zero;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    accept  = 1'b0;
    if (flush) begin
      state_d = MD_IDLE;
      cnt_d   = '0;
    end else begin
      if (busy) begin
        if (cnt_zero) state_d = MD_IDLE;
        else          cnt_d   = cnt_q - 1'b1;
      end
      // Completion cycle frees the unit, so a new op may follow back-to-back.
      if (start && !stall_other && can_issue && !rst) begin
        accept  = 1'b1;
        state_d = MD_BUSY;
        cnt_d   = CW'(MD_LAT - 1);
        pend_d  = rd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  assign state        = state_q;
  assign pend_rd      = pend_q;
  assign wb_valid     = !rst && busy && cnt_zero && !flush;
  assign wb_rd        = wb_valid ? pend_q : '0;
  assign struct_stall = start && busy && !cnt_zero;

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX-side forwarding select, load-use / multi-cycle stall and store-data
// forwarding. Optional counters under `HAZ_STATS_EN.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int RA_W           = 5,
  parameter int NUM_SRC        = 2,
  parameter int NUM_FWD_STAGES = 2,
  parameter int MD_LAT         = 4,
  parameter int SEL_W          = sel_w(NUM_FWD_STAGES)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_SRC*RA_W-1:0]        ex_rs,
  input  logic [NUM_SRC-1:0]             ex_rs_used,
  input  logic                           ex_regw,
  input  logic [RA_W-1:0]                ex_rd,
  input  logic [NUM_FWD_STAGES-1:0]      stg_regw,
  input  logic [NUM_FWD_STAGES*RA_W-1:0] stg_rd,
  input  logic [NUM_FWD_STAGES-1:0]      stg_load,
  input  logic                           mem_store,
  input  logic [RA_W-1:0]                mem_st_src,
  input  logic                           md_start,
  input  logic [RA_W-1:0]                md_rd,
  input  logic                           md_flush,
  output logic [NUM_SRC*SEL_W-1:0]       fwd_sel,
  output logic                           st_fwd,
  output logic                           stall_ex,
  output logic                           md_busy,
  output logic                           md_wb_valid,
  output logic [RA_W-1:0]                md_wb_rd
`ifdef HAZ_STATS_EN
  ,
  output logic [31:0]                    stat_stall_cyc,
  output logic [31:0]                    stat_fwd_cnt,
  output logic [31:0]                    stat_md_ops
`endif
);

  md_state_e       md_state;
  logic [RA_W-1:0] pend_rd;
  logic            md_accept, md_struct;
  logic [NUM_SRC-1:0] lu_vec, raw_vec;
  logic            load_use, md_raw, md_waw;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [RA_W-1:0]           rs;
    logic [NUM_FWD_STAGES-1:0] hit;
    logic [SEL_W-1:0]          sel;

    assign rs = ex_rs[i*RA_W +: RA_W];

    for (genvar k = 0; k < NUM_FWD_STAGES; k++) begin : g_stg
      assign hit[k] = stg_regw[k] && (stg_rd[k*RA_W +: RA_W] == rs) && (rs != '0);
    end

    // Scan oldest to youngest so the youngest matching producer wins.
    always_comb begin
      sel = SEL_W'(FWD_RF);
      for (int k = NUM_FWD_STAGES - 1; k >= 0; k--) begin
        if (ex_rs_used[i] && hit[k]) sel = SEL_W'(k + 1);
      end
    end

    assign fwd_sel[i*SEL_W +: SEL_W] = sel;
    assign lu_vec[i]  = ex_rs_used[i] && hit[STG_MEM] && stg_load[STG_MEM];
    assign raw_vec[i] = md_busy && ex_rs_used[i] && (rs == pend_rd) && (pend_rd != '0);
  end

  if (NUM_FWD_STAGES >= 2) begin : g_st_fwd
    assign st_fwd = mem_store && stg_regw[STG_WB] && (mem_st_src != '0)
                    && (stg_rd[STG_WB*RA_W +: RA_W] == mem_st_src);
  end else begin : g_no_st_fwd
    assign st_fwd = 1'b0;
  end

  md_scoreboard #(
    .RA_W   (RA_W),
    .MD_LAT (MD_LAT)
  ) u_md_sb (
    .clk          (clk),
    .rst          (rst),
    .start        (md_start),
    .stall_other  (load_use),
    .flush        (md_flush),
    .rd           (md_rd),
    .state        (md_state),
    .pend_rd      (pend_rd),
    .wb_valid     (md_wb_valid),
    .wb_rd        (md_wb_rd),
    .accept       (md_accept),
    .struct_stall (md_struct)
  );

  assign md_busy  = (md_state == MD_BUSY);
  assign load_use = |lu_vec;
  assign md_raw   = |raw_vec;
  assign md_waw   = md_busy && ex_regw && (ex_rd == pend_rd);
  assign stall_ex = !rst && (load_use || md_raw || md_waw || md_struct);

`ifdef HAZ_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_stall_cyc <= '0;
      stat_fwd_cnt   <= '0;
      stat_md_ops    <= '0;
    end else begin
      if (stall_ex && stat_stall_cyc != '1) stat_stall_cyc <= stat_stall_cyc + 32'd1;
      if ((|fwd_sel) && !stall_ex && stat_fwd_cnt != '1) stat_fwd_cnt <= stat_fwd_cnt + 32'd1;
      if (md_accept && stat_md_ops != '1) stat_md_ops <= stat_md_ops + 32'd1;
    end
  end
`else
  logic unused_accept;
  assign unused_accept = md_accept;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: forwarding priority, load-use,
// multi-cycle scoreboard timing, flush, reset and store-data forwarding.
module tb_fwd_hazard_unit;
  import fwd_pkg::*;

  localparam int RA_W = 5;
  localparam int NSRC = 2;
  localparam int NFS  = 2;
  localparam int LAT  = 4;
  localparam int SW   = 2;

  logic                 clk, rst;
  logic [NSRC*RA_W-1:0] ex_rs;
  logic [NSRC-1:0]      ex_rs_used;
  logic                 ex_regw;
  logic [RA_W-1:0]      ex_rd;
  logic [NFS-1:0]       stg_regw;
  logic [NFS*RA_W-1:0]  stg_rd;
  logic [NFS-1:0]       stg_load;
  logic                 mem_store;
  logic [RA_W-1:0]      mem_st_src;
  logic                 md_start;
  logic [RA_W-1:0]      md_rd;
  logic                 md_flush;
  logic [NSRC*SW-1:0]   fwd_sel;
  logic                 st_fwd, stall_ex, md_busy, md_wb_valid;
  logic [RA_W-1:0]      md_wb_rd;
`ifdef HAZ_STATS_EN
  logic [31:0]          stat_stall_cyc, stat_fwd_cnt, stat_md_ops;
`endif

  fwd_hazard_unit #(
    .RA_W(RA_W), .NUM_SRC(NSRC), .NUM_FWD_STAGES(NFS), .MD_LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst), .ex_rs(ex_rs), .ex_rs_used(ex_rs_used),
    .ex_regw(ex_regw), .ex_rd(ex_rd), .stg_regw(stg_regw), .stg_rd(stg_rd),
    .stg_load(stg_load), .mem_store(mem_store), .mem_st_src(mem_st_src),
    .md_start(md_start), .md_rd(md_rd), .md_flush(md_flush),
    .fwd_sel(fwd_sel), .st_fwd(st_fwd), .stall_ex(stall_ex),
    .md_busy(md_busy), .md_wb_valid(md_wb_valid), .md_wb_rd(md_wb_rd)
`ifdef HAZ_STATS_EN
    , .stat_stall_cyc(stat_stall_cyc), .stat_fwd_cnt(stat_fwd_cnt),
    .stat_md_ops(stat_md_ops)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_idle();
    ex_rs = '0; ex_rs_used = '0; ex_regw = 1'b0; ex_rd = '0;
    stg_regw = '0; stg_rd = '0; stg_load = '0;
    mem_store = 1'b0; mem_st_src = '0;
    md_start = 1'b0; md_rd = '0; md_flush = 1'b0;
  endtask

  task automatic set_src(input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] used);
    ex_rs = {rs1, rs0};
    ex_rs_used = used;
  endtask

  task automatic set_stg(input logic [1:0] regw, input logic [4:0] rd0,
                         input logic [4:0] rd1, input logic [1:0] load);
    stg_regw = regw;
    stg_rd   = {rd1, rd0};
    stg_load = load;
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    tick();
    tick();
    check("rst_stall", {31'd0, stall_ex}, 32'd0);
    check("rst_busy", {31'd0, md_busy}, 32'd0);
    check("rst_wb_valid", {31'd0, md_wb_valid}, 32'd0);
    check("rst_wb_rd", {27'd0, md_wb_rd}, 32'd0);
    check("rst_fwd_sel", {28'd0, fwd_sel}, 32'd0);
    rst = 1'b0;
    tick();

    // Forwarding priority
    set_src(5'd5, 5'd0, 2'b01);
    set_stg(2'b11, 5'd5, 5'd5, 2'b00); settle();
    check("fwd_youngest", {28'd0, fwd_sel}, 32'h1);
    set_stg(2'b10, 5'd5, 5'd5, 2'b00); settle();
    check("fwd_wb_only", {28'd0, fwd_sel}, 32'h2);
    set_src(5'd0, 5'd0, 2'b11);
    set_stg(2'b11, 5'd0, 5'd0, 2'b00); settle();
    check("fwd_x0", {28'd0, fwd_sel}, 32'h0);
    set_src(5'd5, 5'd7, 2'b11);
    set_stg(2'b11, 5'd7, 5'd5, 2'b00); settle();
    check("fwd_both_src", {28'd0, fwd_sel}, 32'h6);
    set_src(5'd5, 5'd7, 2'b00); settle();
    check("fwd_unused", {28'd0, fwd_sel}, 32'h0);
    check("fwd_no_stall", {31'd0, stall_ex}, 32'd0);

    // Load-use then forward from WB
    drive_idle();
    set_src(5'd0, 5'd7, 2'b10);
    set_stg(2'b01, 5'd7, 5'd0, 2'b01); settle();
    check("lu_stall", {31'd0, stall_ex}, 32'd1);
    check("lu_sel", {28'd0, fwd_sel}, 32'h4);
    tick();
    set_stg(2'b10, 5'd0, 5'd7, 2'b10); settle();
    check("lu_next_sel", {28'd0, fwd_sel}, 32'h8);
    check("lu_next_stall", {31'd0, stall_ex}, 32'd0);
    drive_idle();

    // Basic multi-cycle op, rd=9
    md_start = 1'b1; md_rd = 5'd9; settle();
    check("md_issue_busy", {31'd0, md_busy}, 32'd0);
    check("md_issue_stall", {31'd0, stall_ex}, 32'd0);
    tick();
    md_start = 1'b0;
    set_src(5'd9, 5'd0, 2'b01); settle();
    check("md_c1_busy", {31'd0, md_busy}, 32'd1);
    check("md_raw_stall", {31'd0, stall_ex}, 32'd1);
    check("md_c1_wb", {31'd0, md_wb_valid}, 32'd0);
    tick();
    check("md_c2_wb", {31'd0, md_wb_valid}, 32'd0);
    tick();
    check("md_c3_wb", {31'd0, md_wb_valid}, 32'd0);
    tick();
    check("md_c4_wb", {31'd0, md_wb_valid}, 32'd1);
    check("md_c4_rd", {27'd0, md_wb_rd}, 32'd9);
    check("md_c4_busy", {31'd0, md_busy}, 32'd1);
    tick();
    check("md_done_busy", {31'd0, md_busy}, 32'd0);
    check("md_done_wb", {31'd0, md_wb_valid}, 32'd0);
    check("md_done_rd", {27'd0, md_wb_rd}, 32'd0);
    check("md_done_stall", {31'd0, stall_ex}, 32'd0);
    drive_idle();

    // Structural stall and back-to-back issue
    md_start = 1'b1; md_rd = 5'd10;
    tick();
    md_start = 1'b0;
    tick();
    md_start = 1'b1; md_rd = 5'd11; settle();
    check("b2b_struct_c2", {31'd0, stall_ex}, 32'd1);
    tick();
    check("b2b_struct_c3", {31'd0, stall_ex}, 32'd1);
    tick();
    check("b2b_first_wb", {31'd0, md_wb_valid}, 32'd1);
    check("b2b_first_rd", {27'd0, md_wb_rd}, 32'd10);
    check("b2b_accept_nostall", {31'd0, stall_ex}, 32'd0);
    tick();
    md_start = 1'b0; settle();
    check("b2b_second_busy", {31'd0, md_busy}, 32'd1);
    check("b2b_second_c1_wb", {31'd0, md_wb_valid}, 32'd0);
    tick();
    tick();
    check("b2b_second_c3_wb", {31'd0, md_wb_valid}, 32'd0);
    tick();
    check("b2b_second_wb", {31'd0, md_wb_valid}, 32'd1);
    check("b2b_second_rd", {27'd0, md_wb_rd}, 32'd11);
    tick();
    check("b2b_idle", {31'd0, md_busy}, 32'd0);

    // Flush at cnt=1
    md_start = 1'b1; md_rd = 5'd12;
    tick();
    md_start = 1'b0;
    tick();
    tick();
    md_flush = 1'b1; settle();
    check("fl1_busy", {31'd0, md_busy}, 32'd1);
    check("fl1_wb", {31'd0, md_wb_valid}, 32'd0);
    tick();
    md_flush = 1'b0; settle();
    check("fl1_cleared", {31'd0, md_busy}, 32'd0);
    check("fl1_no_wb", {31'd0, md_wb_valid}, 32'd0);
    tick();
    check("fl1_no_wb_later", {31'd0, md_wb_valid}, 32'd0);

    // Flush on completion cycle suppresses the pulse
    md_start = 1'b1; md_rd = 5'd16;
    tick();
    md_start = 1'b0;
    tick();
    tick();
    tick();
    md_flush = 1'b1; settle();
    check("fl0_wb", {31'd0, md_wb_valid}, 32'd0);
    check("fl0_rd", {27'd0, md_wb_rd}, 32'd0);
    tick();
    md_flush = 1'b0; settle();
    check("fl0_idle", {31'd0, md_busy}, 32'd0);

    // Flush beats same-cycle start
    md_start = 1'b1; md_flush = 1'b1; md_rd = 5'd17;
    tick();
    md_start = 1'b0; md_flush = 1'b0; settle();
    check("fl_beats_start", {31'd0, md_busy}, 32'd0);

    // WAW
    md_start = 1'b1; md_rd = 5'd14;
    tick();
    md_start = 1'b0;
    ex_regw = 1'b1; ex_rd = 5'd14; settle();
    check("waw_stall", {31'd0, stall_ex}, 32'd1);
    ex_rd = 5'd15; settle();
    check("waw_other_rd", {31'd0, stall_ex}, 32'd0);
    ex_regw = 1'b0;
    tick();
    tick();
    tick();
    check("waw_op_wb_rd", {27'd0, md_wb_rd}, 32'd14);
    tick();

    // Load-use blocks md_start; re-presented start is accepted
    set_src(5'd0, 5'd7, 2'b10);
    set_stg(2'b01, 5'd7, 5'd0, 2'b01);
    md_start = 1'b1; md_rd = 5'd20; settle();
    check("lu_md_stall", {31'd0, stall_ex}, 32'd1);
    tick();
    check("lu_md_not_accepted", {31'd0, md_busy}, 32'd0);
    set_stg(2'b00, 5'd0, 5'd0, 2'b00); settle();
    check("lu_md_retry_nostall", {31'd0, stall_ex}, 32'd0);
    tick();
    md_start = 1'b0;
    check("lu_md_accepted", {31'd0, md_busy}, 32'd1);
    tick();
    tick();
    tick();
    check("lu_md_wb_rd", {27'd0, md_wb_rd}, 32'd20);
    tick();
    drive_idle();

    // Reset mid-operation
    md_start = 1'b1; md_rd = 5'd13;
    tick();
    md_start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    set_src(5'd13, 5'd0, 2'b01); settle();
    check("rstmid_stall", {31'd0, stall_ex}, 32'd0);
    check("rstmid_wb", {31'd0, md_wb_valid}, 32'd0);
    tick();
    check("rstmid_busy", {31'd0, md_busy}, 32'd0);
    rst = 1'b0;
    tick();
    check("rstmid_after_wb", {31'd0, md_wb_valid}, 32'd0);
    check("rstmid_after_stall", {31'd0, stall_ex}, 32'd0);
    drive_idle();

    // Store-data forwarding
    mem_store = 1'b1; mem_st_src = 5'd3;
    set_stg(2'b10, 5'd0, 5'd3, 2'b00); settle();
    check("st_fwd_hit", {31'd0, st_fwd}, 32'd1);
    set_stg(2'b01, 5'd3, 5'd0, 2'b00); settle();
    check("st_fwd_mem_only", {31'd0, st_fwd}, 32'd0);
    mem_st_src = 5'd0;
    set_stg(2'b10, 5'd0, 5'd0, 2'b00); settle();
    check("st_fwd_x0", {31'd0, st_fwd}, 32'd0);
    mem_st_src = 5'd3; mem_store = 1'b0;
    set_stg(2'b10, 5'd0, 5'd3, 2'b00); settle();
    check("st_fwd_nostore", {31'd0, st_fwd}, 32'd0);

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the two-stage forwarding control.
- Generalises operand forwarding to NUM_SRC sources and NUM_FWD_STAGES producer stages, with youngest-producer priority.
- Adds load-use stall detection, store-data forwarding, and a sequential scoreboard for one multi-cycle (mul/div) unit with countdown, busy, writeback pulse and flush.
- Sits beside the EX stage; drives the EX operand muxes and the pipeline stall.

Parameters:
- RA_W, 5, register address width.
- NUM_SRC, 2, source operands per EX instruction.
- NUM_FWD_STAGES, 2, producer stages after EX; index 0 = MEM (youngest), 1 = WB.
- MD_LAT, 4, multi-cycle unit latency in cycles (≥2).
- SEL_W, $clog2(NUM_FWD_STAGES+1), forward select width (derived).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ex_rs  in  NUM_SRC*RA_W  EX source addresses (slice i = source i)
- ex_rs_used  in  NUM_SRC  source i actually read
- ex_regw  in  1  EX instruction writes a register
- ex_rd  in  RA_W  EX destination
- stg_regw  in  NUM_FWD_STAGES  stage k writes a register
- stg_rd  in  NUM_FWD_STAGES*RA_W  stage k destination
- stg_load  in  NUM_FWD_STAGES  stage k is a load (data not ready in stage 0)
- mem_store  in  1  MEM instruction is a store
- mem_st_src  in  RA_W  store-data source register of MEM instruction
- md_start  in  1  EX issues a multi-cycle op
- md_rd  in  RA_W  destination of the issued op
- md_flush  in  1  squash pending multi-cycle op
- fwd_sel  out  NUM_SRC*SEL_W  0 = regfile, k+1 = forward from stage k
- st_fwd  out  1  forward stage-1 result to MEM store data
- stall_ex  out  1  hold IF/ID/EX, bubble into MEM
- md_busy  out  1  multi-cycle op pending
- md_wb_valid  out  1  one-cycle result-writeback pulse
- md_wb_rd  out  RA_W  destination for md_wb_valid

Behaviour:
- Match(k,a) = stg_regw[k] & stg_rd[k]==a & a!=0.
- fwd_sel[i] is combinational: lowest k with Match(k,ex_rs[i]) and ex_rs_used[i] gives k+1; no match gives 0.
- Load-use: ex_rs_used[i] & Match(0,ex_rs[i]) & stg_load[0] -> stall_ex=1 that cycle, and fwd_sel[i] is still driven to 1. A load in stage ≥1 forwards normally.
- st_fwd = mem_store & Match(1,mem_st_src) & mem_st_src!=0. Requires NUM_FWD_STAGES≥2; otherwise tied 0.
- Scoreboard registers: md_busy, cnt[$clog2(MD_LAT+1)-1:0], pend_rd.
  - IDLE (md_busy=0): md_start & !stall_other & !md_flush -> md_busy=1, cnt=MD_LAT-1, pend_rd=md_rd.
  - BUSY: cnt decrements each cycle. When cnt==0: md_wb_valid=1, md_wb_rd=pend_rd, md_busy=0 next cycle.
- RAW: md_busy & ex_rs_used[i] & ex_rs[i]==pend_rd & pend_rd!=0 -> stall_ex.
- WAW: md_busy & ex_regw & ex_rd==pend_rd -> stall_ex.
- Structural: md_start & md_busy & cnt!=0 -> stall_ex; the start is not accepted. On the completion cycle (cnt==0) a new md_start is accepted back-to-back.
- stall_other = load-use stall. A stalled md_start is not accepted; it is re-presented next cycle.
- md_flush: clears md_busy next cycle and suppresses md_wb_valid in the same cycle. Flush beats a same-cycle start.
- md_wb_valid and md_wb_rd are combinational from registered state (cnt==0 & md_busy); md_wb_rd=0 when not valid.
- Reset:
  - md_busy=0, cnt=0, pend_rd=0.
  - stall_ex=0, md_wb_valid=0, md_wb_rd=0 while rst=1.
  - fwd_sel and st_fwd are pure combinational.
  - Reset mid-operation drops the pending op with no writeback pulse.

Optional Feature:
- HAZ_STATS_EN defined: adds outputs stat_stall_cyc[31:0], stat_fwd_cnt[31:0], stat_md_ops[31:0].
  - Counters cleared on rst; saturate at all-ones.
  - stat_stall_cyc increments per stall_ex cycle.
  - stat_fwd_cnt increments per cycle with any fwd_sel!=0 and no stall.
  - stat_md_ops increments per accepted md_start.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package fwd_pkg holds:
  - FWD_RF=0 constant.
  - SEL_W function.
  - typedef reg_addr_t logic[RA_W-1:0].
  - Stage-index constants STG_MEM=0, STG_WB=1.
- One sub-module: md_scoreboard (counter, busy, pend_rd, flush).
- Forward priority encoder generated per source inside the top.

Test Plan:
- rs1=5; stage0 and stage1 both write x5 -> fwd_sel[0]=1 (youngest wins). Stage1 only -> 2. rd=0 in both -> 0.
- Stage0 load writes x7; EX rs2=7 used -> stall_ex=1 for one cycle. Next cycle (load now in stage1) -> fwd_sel[1]=2, stall_ex=0.
- md_start, md_rd=9, MD_LAT=4 -> md_busy for 4 cycles; md_wb_valid on the 4th cycle with md_wb_rd=9. EX reading x9 during that window -> stall_ex=1.
- Second md_start at cycle 2 of busy -> stall_ex=1, not accepted. md_start held to completion cycle -> accepted back-to-back, second pulse 4 cycles later.
- md_flush at cnt=1 -> md_busy=0 next cycle, no md_wb_valid. rst asserted mid-op -> same result, all outputs 0.
- MEM store with mem_st_src=3, stage1 writes x3 -> st_fwd=1. mem_st_src=0 -> st_fwd=0.
